// File: rtl/uart_serial_port.sv
// 8N1 UART endpoint between the processor's byte-serial MMIO port and an RX/TX line pair.
// Bytes written by the processor are queued and transmitted; received bytes are queued for reading.

module uart_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB tells full from empty when the index bits match.
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end
endmodule

module uart_serial_port #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] wr_data_in,
   input  logic       wr_en_in,
   output logic       wr_ready_out,
   output logic [7:0] rd_data_out,
   output logic       rd_valid_out,
   input  logic       rd_en_in,
   input  logic       uart_rx_in,
   output logic       uart_tx_out,
   output logic       tx_busy_out,
   output logic       overrun_out,
   output logic       framing_err_out
);
   localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- transmit path ----------------
   tx_state_t     tx_state, tx_state_nx;
   logic [CW-1:0] tx_cnt, tx_cnt_nx;
   logic [2:0]    tx_bit, tx_bit_nx;
   logic [7:0]    tx_shift, tx_shift_nx;
   logic          tx_line, tx_line_nx;
   logic          tx_pop;
   logic [7:0]    tx_head;
   logic          tx_full;
   logic          tx_empty;

   uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_en_in),
      .push_data (wr_data_in),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_line  <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_bit   <= tx_bit_nx;
         tx_shift <= tx_shift_nx;
         tx_line  <= tx_line_nx;
      end
   end

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_bit_nx   = tx_bit;
      tx_shift_nx = tx_shift;
      tx_line_nx  = tx_line;
      tx_pop      = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_line_nx = 1'b1;
            if (!tx_empty) begin
               tx_pop      = 1'b1;
               tx_shift_nx = tx_head;
               tx_cnt_nx   = '0;
               tx_line_nx  = 1'b0;
               tx_state_nx = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nx   = '0;
               tx_bit_nx   = '0;
               tx_line_nx  = tx_shift[0];
               tx_state_nx = TX_DATA;
            end else begin
               tx_cnt_nx = tx_cnt + CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nx = '0;
               if (tx_bit == 3'd7) begin
                  tx_line_nx  = 1'b1;
                  tx_state_nx = TX_STOP;
               end else begin
                  tx_bit_nx   = tx_bit + 3'd1;
                  tx_shift_nx = {1'b0, tx_shift[7:1]};
                  tx_line_nx  = tx_shift[1];
               end
            end else begin
               tx_cnt_nx = tx_cnt + CNT_ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nx = '0;
               // Chain straight into the next start bit so queued frames leave no idle gap.
               if (!tx_empty) begin
                  tx_pop      = 1'b1;
                  tx_shift_nx = tx_head;
                  tx_line_nx  = 1'b0;
                  tx_state_nx = TX_START;
               end else begin
                  tx_line_nx  = 1'b1;
                  tx_state_nx = TX_IDLE;
               end
            end else begin
               tx_cnt_nx = tx_cnt + CNT_ONE;
            end
         end
         default: begin
            tx_line_nx  = 1'b1;
            tx_state_nx = TX_IDLE;
         end
      endcase
   end

   assign uart_tx_out  = tx_line;
   assign wr_ready_out = !tx_full;
   assign tx_busy_out  = (tx_state != TX_IDLE) || !tx_empty;

   // ---------------- receive path ----------------
   rx_state_t     rx_state, rx_state_nx;
   logic [CW-1:0] rx_cnt, rx_cnt_nx;
   logic [2:0]    rx_bit, rx_bit_nx;
   logic [7:0]    rx_shift, rx_shift_nx;
   logic          rx_s1, rx_s2, rx_d;
   logic          rx_push;
   logic          overrun, overrun_nx;
   logic          framing, framing_nx;
   logic [7:0]    rx_head;
   logic          rx_full;
   logic          rx_empty;

   uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_shift),
      .pop       (rd_en_in),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         overrun  <= 1'b0;
         framing  <= 1'b0;
      end else begin
         rx_s1    <= uart_rx_in;
         rx_s2    <= rx_s1;
         rx_d     <= rx_s2;
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         rx_bit   <= rx_bit_nx;
         rx_shift <= rx_shift_nx;
         overrun  <= overrun_nx;
         framing  <= framing_nx;
      end
   end

   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_bit_nx   = rx_bit;
      rx_shift_nx = rx_shift;
      overrun_nx  = overrun;
      framing_nx  = framing;
      rx_push     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            // Arm only on a falling edge, so a line stuck low never retriggers.
            if (rx_d && !rx_s2) begin
               rx_cnt_nx   = '0;
               rx_state_nx = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == CNT_HALF) begin
               rx_cnt_nx   = '0;
               rx_bit_nx   = '0;
               rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_nx = rx_cnt + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_nx   = '0;
               rx_shift_nx = {rx_s2, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
               else                rx_bit_nx   = rx_bit + 3'd1;
            end else begin
               rx_cnt_nx = rx_cnt + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_nx   = '0;
               rx_state_nx = RX_IDLE;
               if (rx_s2) begin
                  rx_push = 1'b1;
                  if (rx_full) overrun_nx = 1'b1;
               end else begin
                  framing_nx = 1'b1;
               end
            end else begin
               rx_cnt_nx = rx_cnt + CNT_ONE;
            end
         end
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   assign rd_valid_out    = !rx_empty;
   assign rd_data_out     = rx_empty ? '0 : rx_head;
   assign overrun_out     = overrun;
   assign framing_err_out = framing;
endmodule

// File: doc/uart_serial_port.md
# uart_serial_port

Byte-serial UART endpoint that sits on the far side of the processor's serial MMIO port and connects it to a physical RX/TX line pair. It accepts bytes the processor writes (serial_out/serial_wren_out) into a TX FIFO and transmits them as 8N1 frames. It also receives 8N1 frames, buffers them in an RX FIFO, and presents them on serial_in/serial_valid_in, popping one on serial_rden_out. It is instantiated at the top level beside the CPU.

## Interface
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be ≥4 and even.
- FIFO_DEPTH, 8: entries per FIFO (TX and RX); must be a power of two, ≥2.

- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- wr_data_in  in  8  byte from processor (connects to serial_out).
- wr_en_in  in  1  push wr_data_in into TX FIFO (connects to serial_wren_out).
- wr_ready_out  out  1  TX FIFO not full (connects to serial_ready_in).
- rd_data_out  out  8  RX FIFO head byte, first-word fall-through (connects to serial_in).
- rd_valid_out  out  1  RX FIFO not empty (connects to serial_valid_in).
- rd_en_in  in  1  pop RX FIFO head (connects to serial_rden_out).
- uart_rx_in  in  1  asynchronous serial input line; idle high.
- uart_tx_out  out  1  serial output line; idle high.
- tx_busy_out  out  1  TX FSM not in IDLE or TX FIFO non-empty.
- overrun_out  out  1  sticky: received byte dropped because RX FIFO was full.
- framing_err_out  out  1  sticky: stop bit sampled low.

## Operation
- Reset values: uart_tx_out=1, wr_ready_out=1, rd_valid_out=0, rd_data_out=0, tx_busy_out=0, overrun_out=0, framing_err_out=0; both FIFOs empty, both FSMs IDLE, RX synchronizer flops =1.
- FIFOs: pointers are log2(FIFO_DEPTH)+1 bits wide, with the MSB used for full/empty disambiguation, and wrap naturally. Full and empty are evaluated on pre-edge state. A push while full is dropped, even if a pop occurs in the same cycle. A pop while empty is ignored. Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- rd_data_out reads 0 when the RX FIFO is empty.
- TX FSM: IDLE→START→DATA→STOP.
  - IDLE: if TX FIFO is non-empty, pop into the shift register and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START, so frames are back-to-back with no gap. Otherwise go to IDLE.
- RX input: 2-flop synchronizer feeding a 1-cycle-delayed copy for edge detection.
- RX FSM: IDLE→START→DATA→STOP.
  - IDLE: on a synchronized 1→0 edge, go to START with counter=0.
  - START: at count CLKS_PER_BIT/2−1, sample. If 0, go to DATA. If 1, it is a false start: return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift LSB first, 8 samples.
  - STOP: sample mid-bit. If 1, push the byte; if the FIFO is full, drop it and set overrun_out. If 0, discard the byte and set framing_err_out. Return to IDLE either way.
  - IDLE re-arms only on a new 1→0 edge, so a line held low after a framing error does not retrigger.
- Sticky flags clear only on reset.

## Timing
- TX latency: wr_en_in sampled at edge N; the FSM pops at edge N+1; uart_tx_out goes low after edge N+1.
- TX frame: exactly 10×CLKS_PER_BIT cycles per byte.
- wr_ready_out falls in the cycle after the push that fills the FIFO.
- RX latency: rd_valid_out rises 1 cycle after the stop-bit sample edge. That edge is 2 (synchronizer) + 1 (edge detect) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles after the line's falling edge, ±1 cycle.
- Pop: rd_en_in with rd_valid_out at edge M; the next byte or empty status is visible after edge M.
- Reset mid-frame: the partial frame is abandoned, uart_tx_out=1 immediately, and FIFO contents are lost.

## Test plan
- Reset then write 0xA5 with CLKS_PER_BIT=16 → uart_tx_out low at cycle N+1, then bits 1,0,1,0,0,1,0,1, then high; 160 cycles; tx_busy_out returns to 0 after the frame.
- Write 9 bytes back-to-back with FIFO_DEPTH=8 while TX is idle → the first is popped into TX and 8 are buffered; wr_ready_out=0 after that. Further writes are dropped. All 9 frames go out contiguously with no idle bits.
- Drive an 8N1 frame of 0x3C on uart_rx_in → rd_valid_out=1, rd_data_out=0x3C at the specified latency; rd_en_in pulse → rd_valid_out=0, rd_data_out=0.
- Send 9 frames without popping → 8 bytes buffered in order, 9th dropped, overrun_out=1 stays set; popping all 8 returns the first 8 bytes.
- Frame with stop bit 0 → no push, framing_err_out=1. A 4-cycle low glitch on idle line → false start, no push, no flags set.
- Assert reset mid-TX frame and mid-RX frame → uart_tx_out=1 immediately, FIFOs empty, flags 0; a subsequent clean frame is received correctly.
